// File: rtl/subseq.sv
// subseq: bit-serial two's-complement subtractor res = ft - st, LSB first, valid/ready in and out
module subseq #(
  parameter int W  = 4,
  parameter int CW = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] ft,
  input  logic [W-1:0] st,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         neg
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [W-1:0] a_sr, b_sr, r_sr, r_nxt;
  logic [CW-1:0] cnt;
  logic borrow, d, bn;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  // one full-subtractor bit slice on the current LSBs, result bit enters at the MSB
  always_comb begin
    d     = a_sr[0] ^ b_sr[0] ^ borrow;
    bn    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
    r_nxt = (r_sr >> 1) | (W'(d) << (W - 1));
  end
  // handshake FSM and serial datapath
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      res    <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr   <= ft;
          b_sr   <= st;
          r_sr   <= '0;
          borrow <= 1'b0;
          cnt    <= '0;
          state  <= RUN;
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          r_sr   <= r_nxt;
          borrow <= bn;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            state <= DONE;
            res   <= r_nxt;
            neg   <= bn;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_subseq.sv
// tb_subseq: directed self-checking bench for subseq (W=4)
module tb_subseq;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rstn, in_valid, in_ready, out_valid, out_ready, neg;
  logic [W-1:0] ft, st, res;
  int compared = 0;
  int mismatched = 0;

  subseq #(.W(W), .CW(3)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .ft(ft), .st(st), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic en);
    ft = a;
    st = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, in_ready, 1'b0);
    for (int i = 1; i < W; i++) begin
      chk({tag, "_early"}, out_valid, 1'b0);
      tick();
    end
    chk({tag, "_early"}, out_valid, 1'b0);
    tick();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_res"}, res, er);
    chk({tag, "_neg"}, neg, en);
  endtask

  task automatic retire(input string tag);
    tick();
    chk({tag, "_ovdrop"}, out_valid, 1'b0);
    chk({tag, "_irdy"}, in_ready, 1'b1);
  endtask

  initial begin
    rstn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    ft = '0;
    st = '0;
    tick();
    tick();
    chk("rst_irdy", in_ready, 1'b1);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_res", res, 4'd0);
    chk("rst_neg", neg, 1'b0);
    rstn = 1'b1;
    tick();

    run_op("s7_3", 4'd7, 4'd3, 4'd4, 1'b0);
    retire("s7_3");
    run_op("s3_7", 4'd3, 4'd7, 4'd12, 1'b1);
    retire("s3_7");
    run_op("s0_1", 4'd0, 4'd1, 4'd15, 1'b1);
    retire("s0_1");
    run_op("s15_15", 4'd15, 4'd15, 4'd0, 1'b0);
    retire("s15_15");
    run_op("s0_0", 4'd0, 4'd0, 4'd0, 1'b0);
    retire("s0_0");
    run_op("s15_0", 4'd15, 4'd0, 4'd15, 1'b0);
    retire("s15_0");

    out_ready = 1'b0;
    run_op("bp", 4'd9, 4'd4, 4'd5, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_ov", out_valid, 1'b1);
      chk("bp_irdy", in_ready, 1'b0);
      chk("bp_res", res, 4'd5);
      chk("bp_neg", neg, 1'b0);
    end
    out_ready = 1'b1;
    retire("bp");

    ft = 4'd5;
    st = 4'd9;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rstn = 1'b0;
    tick();
    chk("mrst_ov", out_valid, 1'b0);
    chk("mrst_res", res, 4'd0);
    chk("mrst_neg", neg, 1'b0);
    chk("mrst_irdy", in_ready, 1'b1);
    rstn = 1'b1;
    run_op("s2_1", 4'd2, 4'd1, 4'd1, 1'b0);
    retire("s2_1");

    ft = 4'd8;
    st = 4'd2;
    in_valid = 1'b1;
    tick();
    ft = 4'd1;
    st = 4'd1;
    for (int i = 0; i < W - 1; i++) begin
      chk("bi_busy", in_ready, 1'b0);
      chk("bi_early", out_valid, 1'b0);
      tick();
    end
    tick();
    chk("bi_valid", out_valid, 1'b1);
    chk("bi_res", res, 4'd6);
    chk("bi_neg", neg, 1'b0);
    tick();
    chk("bi_ovdrop", out_valid, 1'b0);
    chk("bi_irdy", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("bi2_busy", in_ready, 1'b0);
    for (int i = 0; i < W - 1; i++) tick();
    chk("bi2_early", out_valid, 1'b0);
    tick();
    chk("bi2_valid", out_valid, 1'b1);
    chk("bi2_res", res, 4'd0);
    chk("bi2_neg", neg, 1'b0);
    retire("bi2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
